// File: rtl/dma_wr_desc_arb_pkg.sv
// Shared helpers for the write-descriptor arbiter.
// Contents: a width function that returns the port index width, never less than 1.
package dma_wr_desc_arb_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_wr_desc_arb_rr.sv
// Round-robin arbiter, block mode. A request is granted in the cycle it is
// presented, and the pointer advances only when a grant is issued. Priority
// begins one past the last granted index. After reset that is index 0.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   request      per-requester request vector
//   grant        one-hot grant (combinational)
//   grant_valid  any grant this cycle
//   grant_index  encoded index of the granted requester
import dma_wr_desc_arb_pkg::*;

module dma_wr_desc_arb_rr #(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  request,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_index
);

    logic [IW-1:0] last_q;
    logic          hit;
    logic [IW-1:0] idx;

    // First pass: lowest requester above the last grant. Second pass: wrap to
    // the lowest requester overall.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!hit && request[i] && (IW'(i) > last_q)) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && request[i]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

    always_comb begin
        grant       = '0;
        grant_valid = hit;
        grant_index = idx;
        if (hit) grant = N'(1) << idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else if (hit) begin
            last_q <= idx;
        end
    end

endmodule

// File: rtl/dma_wr_desc_arb.sv
// Shares one PCIe write DMA descriptor input among PORTS requesters.
// Forwarded descriptors carry the source port in the upper bits of ram_sel
// and tag. Each port may have at most MAX_OUTSTANDING descriptors in flight.
// Completion status is routed back to the port encoded in the tag.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   s_axis_write_desc_*            per-port descriptors, port 0 in LSBs
//   m_axis_write_desc_*            registered descriptor to the engine
//   s_axis_write_desc_status_*     completion from the engine
//   m_axis_write_desc_status_*     per-port completion, one-cycle pulse
//   enable                         gates new grants only
//   outstanding_count              per-port in-flight count (debug)
import dma_wr_desc_arb_pkg::*;

module dma_wr_desc_arb #(
    parameter int PORTS           = 4,
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int S_RAM_SEL_WIDTH = 2,
    parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + $clog2(PORTS),
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 16,
    parameter int S_TAG_WIDTH     = 6,
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [PORTS*PCIE_ADDR_WIDTH-1:0] s_axis_write_desc_pcie_addr,
    input  logic [PORTS*S_RAM_SEL_WIDTH-1:0] s_axis_write_desc_ram_sel,
    input  logic [PORTS*RAM_ADDR_WIDTH-1:0]  s_axis_write_desc_ram_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]       s_axis_write_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]     s_axis_write_desc_tag,
    input  logic [PORTS-1:0]                 s_axis_write_desc_valid,
    output logic [PORTS-1:0]                 s_axis_write_desc_ready,

    output logic [PCIE_ADDR_WIDTH-1:0]       m_axis_write_desc_pcie_addr,
    output logic [M_RAM_SEL_WIDTH-1:0]       m_axis_write_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0]        m_axis_write_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]             m_axis_write_desc_len,
    output logic [M_TAG_WIDTH-1:0]           m_axis_write_desc_tag,
    output logic                             m_axis_write_desc_valid,
    input  logic                             m_axis_write_desc_ready,

    input  logic [M_TAG_WIDTH-1:0]           s_axis_write_desc_status_tag,
    input  logic                             s_axis_write_desc_status_valid,
    output logic [PORTS*S_TAG_WIDTH-1:0]     m_axis_write_desc_status_tag,
    output logic [PORTS-1:0]                 m_axis_write_desc_status_valid,

    input  logic                             enable,
    output logic [PORTS*($clog2(MAX_OUTSTANDING)+1)-1:0] outstanding_count
);

    localparam int PW = idx_width(PORTS);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);
    localparam logic [PW:0]   PORTS_LIM = (PW+1)'(PORTS);

    logic [CW-1:0]    cnt_q [PORTS];
    logic [PORTS-1:0] eligible;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [PW-1:0]    grant_index;
    logic             out_free;

    logic [PW-1:0]    stat_port;
    logic             stat_hit;
    logic [PORTS-1:0] cnt_inc;
    logic [PORTS-1:0] cnt_dec;

    // The output register can accept a new entry when it is empty or is
    // being drained this cycle.
    assign out_free = !m_axis_write_desc_valid || m_axis_write_desc_ready;

    // Qualifying with rst_n keeps ready low while reset is held.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < PORTS; i++) begin
            eligible[i] = rst_n && enable && out_free &&
                          s_axis_write_desc_valid[i] && (cnt_q[i] < MAX_CNT);
        end
    end

    dma_wr_desc_arb_rr #(
        .N  (PORTS),
        .IW (PW)
    ) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (eligible),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    assign s_axis_write_desc_ready = grant;

    assign stat_port = s_axis_write_desc_status_tag[M_TAG_WIDTH-1 -: PW];
    // The port index can decode above PORTS-1 when PORTS is not a power of two.
    // Such a status is discarded.
    assign stat_hit  = s_axis_write_desc_status_valid && ({1'b0, stat_port} < PORTS_LIM);

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int i = 0; i < PORTS; i++) begin
            cnt_inc[i] = grant_valid && (grant_index == PW'(i));
            cnt_dec[i] = stat_hit && (stat_port == PW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_write_desc_pcie_addr <= '0;
            m_axis_write_desc_ram_sel   <= '0;
            m_axis_write_desc_ram_addr  <= '0;
            m_axis_write_desc_len       <= '0;
            m_axis_write_desc_tag       <= '0;
            m_axis_write_desc_valid     <= 1'b0;
        end else if (grant_valid) begin
            m_axis_write_desc_pcie_addr <= s_axis_write_desc_pcie_addr[grant_index*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
            m_axis_write_desc_ram_sel   <= M_RAM_SEL_WIDTH'({grant_index,
                                           s_axis_write_desc_ram_sel[grant_index*S_RAM_SEL_WIDTH +: S_RAM_SEL_WIDTH]});
            m_axis_write_desc_ram_addr  <= s_axis_write_desc_ram_addr[grant_index*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            m_axis_write_desc_len       <= s_axis_write_desc_len[grant_index*LEN_WIDTH +: LEN_WIDTH];
            m_axis_write_desc_tag       <= M_TAG_WIDTH'({grant_index,
                                           s_axis_write_desc_tag[grant_index*S_TAG_WIDTH +: S_TAG_WIDTH]});
            m_axis_write_desc_valid     <= 1'b1;
        end else if (m_axis_write_desc_ready) begin
            m_axis_write_desc_valid     <= 1'b0;
        end
    end

    // A grant and a status on the same port cancel out. A status on an idle
    // port saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PORTS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (cnt_dec[i] && !cnt_inc[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_write_desc_status_tag   <= '0;
            m_axis_write_desc_status_valid <= '0;
        end else begin
            m_axis_write_desc_status_valid <= cnt_dec;
            if (stat_hit) begin
                m_axis_write_desc_status_tag[stat_port*S_TAG_WIDTH +: S_TAG_WIDTH] <=
                    s_axis_write_desc_status_tag[S_TAG_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        outstanding_count = '0;
        for (int i = 0; i < PORTS; i++) begin
            outstanding_count[i*CW +: CW] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_dma_wr_desc_arb.sv
module tb_dma_wr_desc_arb;

    localparam int PORTS = 4;
    localparam int AW    = 64;
    localparam int SSW   = 2;
    localparam int MSW   = 4;
    localparam int RAW   = 16;
    localparam int LW    = 16;
    localparam int STW   = 6;
    localparam int MTW   = 8;
    localparam int CW    = 4;

    logic clk;
    logic rst_n;

    logic [PORTS*AW-1:0]  s_pcie_addr;
    logic [PORTS*SSW-1:0] s_ram_sel;
    logic [PORTS*RAW-1:0] s_ram_addr;
    logic [PORTS*LW-1:0]  s_len;
    logic [PORTS*STW-1:0] s_tag;
    logic [PORTS-1:0]     s_valid;
    logic [PORTS-1:0]     s_ready;

    logic [AW-1:0]        m_pcie_addr;
    logic [MSW-1:0]       m_ram_sel;
    logic [RAW-1:0]       m_ram_addr;
    logic [LW-1:0]        m_len;
    logic [MTW-1:0]       m_tag;
    logic                 m_valid;
    logic                 m_ready;

    logic [MTW-1:0]       st_tag;
    logic                 st_valid;
    logic [PORTS*STW-1:0] ms_tag;
    logic [PORTS-1:0]     ms_valid;

    logic                 enable;
    logic [PORTS*CW-1:0]  counts;

    int n_tests = 0;
    int n_fail  = 0;

    dma_wr_desc_arb dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .s_axis_write_desc_pcie_addr    (s_pcie_addr),
        .s_axis_write_desc_ram_sel      (s_ram_sel),
        .s_axis_write_desc_ram_addr     (s_ram_addr),
        .s_axis_write_desc_len          (s_len),
        .s_axis_write_desc_tag          (s_tag),
        .s_axis_write_desc_valid        (s_valid),
        .s_axis_write_desc_ready        (s_ready),
        .m_axis_write_desc_pcie_addr    (m_pcie_addr),
        .m_axis_write_desc_ram_sel      (m_ram_sel),
        .m_axis_write_desc_ram_addr     (m_ram_addr),
        .m_axis_write_desc_len          (m_len),
        .m_axis_write_desc_tag          (m_tag),
        .m_axis_write_desc_valid        (m_valid),
        .m_axis_write_desc_ready        (m_ready),
        .s_axis_write_desc_status_tag   (st_tag),
        .s_axis_write_desc_status_valid (st_valid),
        .m_axis_write_desc_status_tag   (ms_tag),
        .m_axis_write_desc_status_valid (ms_valid),
        .enable                         (enable),
        .outstanding_count              (counts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [SSW-1:0] sel,
                            input logic [RAW-1:0] ra, input logic [LW-1:0] len,
                            input logic [STW-1:0] tag);
        s_pcie_addr[p*AW +: AW]   = a;
        s_ram_sel[p*SSW +: SSW]   = sel;
        s_ram_addr[p*RAW +: RAW]  = ra;
        s_len[p*LW +: LW]         = len;
        s_tag[p*STW +: STW]       = tag;
    endtask

    task automatic do_reset;
        rst_n       = 1'b0;
        s_valid     = '0;
        m_ready     = 1'b0;
        st_tag      = '0;
        st_valid    = 1'b0;
        enable      = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        s_pcie_addr = '0;
        s_ram_sel   = '0;
        s_ram_addr  = '0;
        s_len       = '0;
        s_tag       = '0;
        s_valid     = 4'b1111;
        m_ready     = 1'b1;
        st_tag      = '0;
        st_valid    = 1'b0;
        enable      = 1'b1;
        step();
        n_tests++;
        if (m_valid !== 1'b0 || ms_valid !== 4'b0000 || counts !== 16'h0000 || m_tag !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: m_valid=%b status_valid=%b counts=%h m_tag=%h, required 0/0000/0000/00",
                     m_valid, ms_valid, counts, m_tag);
        end
        n_tests++;
        if (s_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b, required 0000", s_ready);
        end
        s_valid = '0;
        rst_n   = 1'b1;
    endtask

    task automatic test_single_port;
        do_reset();
        m_ready = 1'b1;
        set_port(0, 64'h1000, 2'd1, 16'h0040, 16'd64, 6'd5);
        s_valid = 4'b0001;
        #1;
        n_tests++;
        if (s_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: ready=%b, required 0001", s_ready);
        end
        step();
        s_valid = '0;
        n_tests++;
        if (m_valid !== 1'b1 || m_ram_sel !== 4'b0001 || m_tag !== 8'h05 ||
            m_pcie_addr !== 64'h1000 || m_ram_addr !== 16'h0040 || m_len !== 16'd64) begin
            n_fail++;
            $display("FAIL single_desc: valid=%b sel=%h tag=%h addr=%h raddr=%h len=%0d, required 1/1/05/1000/0040/64",
                     m_valid, m_ram_sel, m_tag, m_pcie_addr, m_ram_addr, m_len);
        end
        n_tests++;
        if (counts[0 +: CW] !== 4'd1) begin
            n_fail++;
            $display("FAIL single_count_inc: count0=%0d, required 1", counts[0 +: CW]);
        end
        step();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: m_valid=%b, required 0", m_valid);
        end
        st_tag   = 8'h05;
        st_valid = 1'b1;
        step();
        st_valid = 1'b0;
        n_tests++;
        if (ms_valid !== 4'b0001 || ms_tag[0 +: STW] !== 6'd5 || counts[0 +: CW] !== 4'd0) begin
            n_fail++;
            $display("FAIL single_status: status_valid=%b tag=%0d count0=%0d, required 0001/5/0",
                     ms_valid, ms_tag[0 +: STW], counts[0 +: CW]);
        end
        step();
        n_tests++;
        if (ms_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_status_pulse: status_valid=%b, required 0000", ms_valid);
        end
    endtask

    task automatic test_round_robin;
        int exp;
        do_reset();
        m_ready = 1'b1;
        for (int p = 0; p < PORTS; p++)
            set_port(p, AW'(p * 256), SSW'(p), RAW'(p), LW'(p + 1), STW'(p + 8));
        s_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp = k % 4;
            #1;
            n_tests++;
            if (s_ready !== (4'b0001 << exp)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: ready=%b, required port %0d", k, s_ready, exp);
            end
            step();
            n_tests++;
            if (m_valid !== 1'b1 || m_tag !== {2'(exp), 6'(exp + 8)} || m_ram_sel !== {2'(exp), 2'(exp)}) begin
                n_fail++;
                $display("FAIL rr_desc[%0d]: valid=%b tag=%h sel=%h, required port %0d", k, m_valid, m_tag, m_ram_sel, exp);
            end
        end
        s_valid = '0;
        n_tests++;
        if (counts !== 16'h2222) begin
            n_fail++;
            $display("FAIL rr_counts: counts=%h, required 2222", counts);
        end
    endtask

    task automatic test_outstanding_limit;
        do_reset();
        m_ready = 1'b1;
        set_port(2, 64'h2200, 2'd2, 16'h0022, 16'd8, 6'h22);
        set_port(0, 64'h0300, 2'd0, 16'h0003, 16'd4, 6'h03);
        s_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_tests++;
            if (s_ready !== 4'b0100) begin
                n_fail++;
                $display("FAIL limit_fill[%0d]: ready=%b, required 0100", k, s_ready);
            end
            step();
        end
        n_tests++;
        if (counts[2*CW +: CW] !== 4'd8) begin
            n_fail++;
            $display("FAIL limit_count_full: count2=%0d, required 8", counts[2*CW +: CW]);
        end
        #1;
        n_tests++;
        if (s_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL limit_masked: ready=%b, required 0000", s_ready);
        end
        s_valid = 4'b0101;
        #1;
        n_tests++;
        if (s_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL limit_other_port: ready=%b, required 0001", s_ready);
        end
        step();
        s_valid  = 4'b0100;
        st_tag   = {2'd2, 6'd7};
        st_valid = 1'b1;
        n_tests++;
        if (m_tag !== 8'h03) begin
            n_fail++;
            $display("FAIL limit_other_desc: tag=%h, required 03", m_tag);
        end
        step();
        st_valid = 1'b0;
        n_tests++;
        if (counts[2*CW +: CW] !== 4'd7 || ms_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL limit_release: count2=%0d status_valid=%b, required 7/0100", counts[2*CW +: CW], ms_valid);
        end
        #1;
        n_tests++;
        if (s_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL limit_regrant: ready=%b, required 0100", s_ready);
        end
        step();
        s_valid = '0;
        n_tests++;
        if (counts[2*CW +: CW] !== 4'd8 || m_tag !== 8'hA2) begin
            n_fail++;
            $display("FAIL limit_refill: count2=%0d tag=%h, required 8/A2", counts[2*CW +: CW], m_tag);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        m_ready = 1'b0;
        set_port(3, 64'hAAAA, 2'd1, 16'h0A0A, 16'd16, 6'h2A);
        s_valid = 4'b1000;
        #1;
        n_tests++;
        if (s_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_first_grant: ready=%b, required 1000", s_ready);
        end
        step();
        set_port(3, 64'hBBBB, 2'd2, 16'h0B0B, 16'd32, 6'h15);
        set_port(1, 64'h1111, 2'd3, 16'h0101, 16'd48, 6'h11);
        s_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if (s_ready !== 4'b0000 || m_valid !== 1'b1 || m_tag !== 8'hEA ||
                m_pcie_addr !== 64'hAAAA || m_ram_sel !== 4'hD || m_len !== 16'd16) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: ready=%b valid=%b tag=%h addr=%h sel=%h len=%0d, required 0000/1/EA/AAAA/D/16",
                         k, s_ready, m_valid, m_tag, m_pcie_addr, m_ram_sel, m_len);
            end
            step();
        end
        m_ready = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_resume_grant: ready=%b, required 0010", s_ready);
        end
        step();
        n_tests++;
        if (m_valid !== 1'b1 || m_tag !== 8'h51 || m_pcie_addr !== 64'h1111) begin
            n_fail++;
            $display("FAIL bp_resume_desc1: valid=%b tag=%h addr=%h, required 1/51/1111", m_valid, m_tag, m_pcie_addr);
        end
        #1;
        n_tests++;
        if (s_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_resume_grant2: ready=%b, required 1000", s_ready);
        end
        step();
        s_valid = '0;
        n_tests++;
        if (m_valid !== 1'b1 || m_tag !== 8'hD5 || m_pcie_addr !== 64'hBBBB) begin
            n_fail++;
            $display("FAIL bp_resume_desc2: valid=%b tag=%h addr=%h, required 1/D5/BBBB", m_valid, m_tag, m_pcie_addr);
        end
        step();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: m_valid=%b, required 0", m_valid);
        end
    endtask

    task automatic test_simultaneous;
        do_reset();
        m_ready = 1'b1;
        set_port(1, 64'h4000, 2'd0, 16'h0004, 16'd4, 6'h04);
        s_valid = 4'b0010;
        step();
        n_tests++;
        if (counts[1*CW +: CW] !== 4'd1) begin
            n_fail++;
            $display("FAIL simul_pre_count: count1=%0d, required 1", counts[1*CW +: CW]);
        end
        st_tag   = 8'h44;
        st_valid = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL simul_grant: ready=%b, required 0010", s_ready);
        end
        step();
        s_valid  = '0;
        st_valid = 1'b0;
        n_tests++;
        if (counts[1*CW +: CW] !== 4'd1 || ms_valid !== 4'b0010 || ms_tag[1*STW +: STW] !== 6'h04) begin
            n_fail++;
            $display("FAIL simul_same_cycle: count1=%0d status_valid=%b tag=%h, required 1/0010/04",
                     counts[1*CW +: CW], ms_valid, ms_tag[1*STW +: STW]);
        end
        st_tag   = 8'hC9;
        st_valid = 1'b1;
        step();
        st_valid = 1'b0;
        n_tests++;
        if (counts[3*CW +: CW] !== 4'd0 || ms_valid !== 4'b1000 || ms_tag[3*STW +: STW] !== 6'h09) begin
            n_fail++;
            $display("FAIL simul_saturate: count3=%0d status_valid=%b tag=%h, required 0/1000/09",
                     counts[3*CW +: CW], ms_valid, ms_tag[3*STW +: STW]);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        m_ready = 1'b0;
        for (int p = 0; p < PORTS; p++)
            set_port(p, AW'(p + 16), SSW'(p), RAW'(p), LW'(p), STW'(p + 1));
        s_valid = 4'b0001;
        step();
        s_valid  = '0;
        st_tag   = 8'h83;
        st_valid = 1'b1;
        step();
        st_valid = 1'b0;
        n_tests++;
        if (m_valid !== 1'b1 || ms_valid !== 4'b0100 || counts[0 +: CW] !== 4'd1) begin
            n_fail++;
            $display("FAIL rmid_pre: valid=%b status_valid=%b count0=%0d, required 1/0100/1",
                     m_valid, ms_valid, counts[0 +: CW]);
        end
        rst_n   = 1'b0;
        s_valid = 4'b1111;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || ms_valid !== 4'b0000 || counts !== 16'h0000 || s_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_async: valid=%b status_valid=%b counts=%h ready=%b, required 0/0000/0000/0000",
                     m_valid, ms_valid, counts, s_ready);
        end
        step();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rmid_restart: ready=%b, required 0001", s_ready);
        end
        step();
        s_valid = '0;
        n_tests++;
        if (m_valid !== 1'b1 || m_tag !== 8'h01) begin
            n_fail++;
            $display("FAIL rmid_first_desc: valid=%b tag=%h, required 1/01", m_valid, m_tag);
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_outstanding_limit();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
